// File: rtl/mpc_qp_admm_vx_pkg.sv
// Shared types and constants for the ADMM vector stream reader.
// FSM state encoding, default geometry and skid depth.
package mpc_qp_admm_vx_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int ADDR_RANGE = 24;
   localparam int SKID_DEPTH = 2;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/mpc_qp_admm_vx_skid.sv
// Two-entry skid FIFO between the RAM read port and the stream.
// Writer guarantees it never pushes into a full buffer.
module mpc_qp_admm_vx_skid
   import mpc_qp_admm_vx_pkg::*;
#(
   parameter int DataWidth = DATA_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [DataWidth-1:0] in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   output logic [DataWidth-1:0] out_data,
   output logic                 out_last,
   input  logic                 out_ready,
   output logic [1:0]           count
);

   logic [DataWidth-1:0]  mem [SKID_DEPTH];
   logic [SKID_DEPTH-1:0] lst;
   logic                  wr;
   logic                  rd;
   logic                  pop;

   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd];
   assign out_last  = lst[rd] & out_valid;
   assign pop       = out_valid & out_ready;

   // Push/pop pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
         lst   <= '0;
         wr    <= 1'b0;
         rd    <= 1'b0;
         count <= 2'd0;
      end else begin
         if (in_valid) begin
            mem[wr] <= in_data;
            lst[wr] <= in_last;
            wr      <= ~wr;
         end
         if (pop) rd <= ~rd;
         count <= count + {1'b0, in_valid} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/mpc_qp_admm_vx_stream_reader.sv
// Streams a (strided, wrapping) vector out of a RAM read port.
// Optional MPC_QP_ADMM_VX_STRIDE_EN adds a stride input (else 1).
module mpc_qp_admm_vx_stream_reader
   import mpc_qp_admm_vx_pkg::*;
#(
   parameter int DataWidth    = DATA_WIDTH,
   parameter int AddressWidth = ADDR_WIDTH,
   parameter int AddressRange = ADDR_RANGE
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [AddressWidth-1:0] base,
   input  logic [AddressWidth:0]   len,
`ifdef MPC_QP_ADMM_VX_STRIDE_EN
   input  logic [AddressWidth-1:0] stride,
`endif
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [AddressWidth-1:0] address1,
   output logic                    ce1,
   input  logic [DataWidth-1:0]    q1,
   output logic [DataWidth-1:0]    m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_last
);

   localparam logic [AddressWidth:0] RANGE =
      (AddressWidth+1)'(AddressRange);
   localparam logic [AddressWidth:0] ONE =
      (AddressWidth+1)'(1);

   state_t                  state;
   logic [AddressWidth-1:0] addr;
   logic [AddressWidth-1:0] stride_r;
   logic [AddressWidth-1:0] stride_in;
   logic [AddressWidth-1:0] nxt;
   logic [AddressWidth:0]   left;
   logic [AddressWidth:0]   sum;
   logic [AddressWidth:0]   wrap;
   logic                    rd_pend;
   logic                    rd_last;
   logic                    bad;
   logic                    pop;
   logic [1:0]              cnt;
   logic [2:0]              occ;

`ifdef MPC_QP_ADMM_VX_STRIDE_EN
   assign stride_in = stride;
`else
   assign stride_in = AddressWidth'(1);
`endif

   assign bad = ({1'b0, base} >= RANGE) || (len > RANGE)
             || ({1'b0, stride_in} >= RANGE);

   // Next element address, wrapped by one conditional subtract
   always_comb begin
      sum  = {1'b0, addr} + {1'b0, stride_r};
      wrap = sum - RANGE;
      nxt  = (sum >= RANGE) ? wrap[AddressWidth-1:0]
                            : sum[AddressWidth-1:0];
   end

   // Count the word leaving this cycle so a full pipe keeps flowing
   assign pop      = m_valid & m_ready;
   assign occ      = {2'b0, rd_pend} + {1'b0, cnt} - {2'b0, pop};
   assign ce1      = (state == ST_RUN) && (occ < 3'd2);
   assign busy     = (state != ST_IDLE);
   assign address1 = addr;

   // Control FSM: accept/reject start, issue reads, finish on last
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         addr     <= '0;
         stride_r <= '0;
         left     <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (bad) begin
                     err <= 1'b1;
                  end else if (len == '0) begin
                     done <= 1'b1;
                  end else begin
                     state    <= ST_RUN;
                     addr     <= base;
                     stride_r <= stride_in;
                     left     <= len;
                  end
               end
            end
            ST_RUN: begin
               if (ce1) begin
                  addr <= nxt;
                  left <= left - ONE;
                  if (left == ONE) state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (pop && m_last) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Track the read in flight and whether it is the final element
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend <= 1'b0;
         rd_last <= 1'b0;
      end else begin
         rd_pend <= ce1;
         rd_last <= ce1 && (left == ONE);
      end
   end

   mpc_qp_admm_vx_skid #(
      .DataWidth (DataWidth)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rd_pend),
      .in_data   (q1),
      .in_last   (rd_last),
      .out_valid (m_valid),
      .out_data  (m_data),
      .out_last  (m_last),
      .out_ready (m_ready),
      .count     (cnt)
   );

endmodule

// File: tb/tb_mpc_qp_admm_vx_stream_reader.sv
// Randomized bench for the vector stream reader with a RAM model.
// Expected streams come from base/len/stride modular arithmetic.
module tb_mpc_qp_admm_vx_stream_reader;

   localparam int AR = 24;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  base;
   logic [5:0]  len;
`ifdef MPC_QP_ADMM_VX_STRIDE_EN
   logic [4:0]  stride;
`endif
   logic        busy, done, err, ce1;
   logic [4:0]  address1;
   logic [31:0] q1;
   logic [31:0] m_data;
   logic        m_valid, m_ready, m_last;

   logic [31:0] ram [AR];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int          aq[$];
   int          cc[$];
   logic [31:0] bd[$];
   bit          bl[$];
   int          bc[$];
   int done_cnt, err_cnt, stall_viol, occ_viol, bad_addr;
   int issued, delivered, done_cyc, start_cyc;
   bit done_busy, pstall, pl;
   logic [31:0] pd;

   mpc_qp_admm_vx_stream_reader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .base     (base),
      .len      (len),
`ifdef MPC_QP_ADMM_VX_STRIDE_EN
      .stride   (stride),
`endif
      .busy     (busy),
      .done     (done),
      .err      (err),
      .address1 (address1),
      .ce1      (ce1),
      .q1       (q1),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_last   (m_last)
   );

   always #5 clk = ~clk;

   // RAM with one-cycle read latency
   always @(posedge clk) begin
      cyc++;
      if (ce1) q1 <= (address1 < 5'(AR)) ? ram[address1] : '0;
   end

   // Monitor: records reads, beats, pulses and protocol violations
   always @(negedge clk) begin
      if (reset) begin
         issued = 0; delivered = 0; pstall = 0;
      end else begin
         if (ce1) begin
            aq.push_back(int'(address1));
            cc.push_back(cyc);
            issued++;
            if (address1 >= 5'(AR)) bad_addr++;
         end
         if (pstall && (!m_valid || m_data !== pd || m_last !== pl))
            stall_viol++;
         if (m_valid && m_ready) begin
            bd.push_back(m_data);
            bl.push_back(m_last);
            bc.push_back(cyc);
            delivered++;
         end
         if (issued - delivered > 2) occ_viol++;
         if (done) begin
            done_cnt++; done_cyc = cyc; done_busy = busy;
         end
         if (err) err_cnt++;
         pstall = m_valid && !m_ready;
         pd = m_data;
         pl = m_last;
      end
   end

   task automatic clear();
      aq.delete(); cc.delete(); bd.delete(); bl.delete(); bc.delete();
      done_cnt = 0; err_cnt = 0; stall_viol = 0; occ_viol = 0;
      bad_addr = 0; done_busy = 0; done_cyc = -1;
   endtask

   task automatic start_vec(input int b, input int l, input int s);
      start = 1'b1;
      base  = 5'(b);
      len   = 6'(l);
`ifdef MPC_QP_ADMM_VX_STRIDE_EN
      stride = 5'(s);
`else
      if (s != 1) $display("note: stride %0d ignored", s);
`endif
      @(posedge clk); #1;
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input int budget, input bit rnd,
                            output bit to);
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (rnd) m_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (done) begin to = 1'b0; break; end
      end
      m_ready = 1'b1;
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, err, ce1, m_valid, m_last} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctl got %b want 000000",
                  {busy, done, err, ce1, m_valid, m_last});
      end
      checks++;
      if (m_data !== 32'h0 || address1 !== 5'h0) begin
         errors++;
         $display("FAIL reset_data got %h/%h want 0/0", m_data, address1);
      end
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, err, ce1, m_valid, m_last} !== 6'b0) begin
         errors++;
         $display("FAIL after_reset got %b want 000000",
                  {busy, done, err, ce1, m_valid, m_last});
      end
   endtask

   task automatic test_full();
      bit to;
      int bad = 0;
      clear(); m_ready = 1'b1;
      start_vec(0, 24, 1);
      wait_done(100, 0, to);
      checks++;
      if (to) begin errors++; $display("FAIL full_timeout no done"); end
      if (bd.size() != 24) bad++;
      else for (int k = 0; k < 24; k++) begin
         if (bd[k] !== ram[k] || bl[k] !== (k == 23)) bad++;
         if (bc[k] != start_cyc + 2 + k) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL full_stream bad=%0d beats=%0d want 24", bad, bd.size());
      end
      checks++;
      if (cc.size() != 24 || (cc.size() > 0 && cc[0] != start_cyc)) begin
         errors++;
         $display("FAIL full_ce1 count=%0d want 24 first@start", cc.size());
      end
      checks++;
      if (done_cnt != 1 || done_busy !== 1'b0
          || (bc.size() > 0 && done_cyc != bc[bc.size()-1] + 1)) begin
         errors++;
         $display("FAIL full_done cnt=%0d busy=%b cyc=%0d want 1/0/last+1",
                  done_cnt, done_busy, done_cyc);
      end
      checks++;
      if (occ_viol != 0 || bad_addr != 0) begin
         errors++;
         $display("FAIL full_occ occ=%0d addr=%0d want 0/0", occ_viol, bad_addr);
      end
   endtask

   task automatic test_wrap();
      bit to;
      int bad = 0;
      clear(); m_ready = 1'b1;
      start_vec(20, 8, 1);
      wait_done(60, 0, to);
      if (to || aq.size() != 8 || bd.size() != 8) bad++;
      else for (int k = 0; k < 8; k++) begin
         if (aq[k] != (20 + k) % AR) bad++;
         if (bd[k] !== ram[(20 + k) % AR] || bl[k] !== (k == 7)) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wrap bad=%0d addrs=%0d want 0/8", bad, aq.size());
      end
   endtask

   task automatic test_backpressure();
      bit to;
      int bad = 0;
      int b = $urandom_range(0, AR - 1);
      clear();
      start_vec(b, 10, 1);
      wait_done(400, 1, to);
      if (to || bd.size() != 10) bad++;
      else for (int k = 0; k < 10; k++)
         if (bd[k] !== ram[(b + k) % AR] || bl[k] !== (k == 9)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_stream bad=%0d beats=%0d want 0/10", bad, bd.size());
      end
      checks++;
      if (stall_viol != 0 || occ_viol != 0 || done_cnt != 1) begin
         errors++;
         $display("FAIL bp_proto stall=%0d occ=%0d done=%0d want 0/0/1",
                  stall_viol, occ_viol, done_cnt);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         bit to;
         int bad = 0;
         int b = $urandom_range(0, AR - 1);
         int l = $urandom_range(1, AR);
         clear();
         start_vec(b, l, 1);
         wait_done(800, 1, to);
         if (to || bd.size() != l) bad++;
         else for (int k = 0; k < l; k++)
            if (bd[k] !== ram[(b + k) % AR] || bl[k] !== (k == l - 1)) bad++;
         if (stall_viol != 0 || occ_viol != 0 || bad_addr != 0) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL random_%0d b=%0d l=%0d bad=%0d want 0", n, b, l, bad);
         end
      end
   endtask

   task automatic test_errors();
      clear(); m_ready = 1'b1;
      start_vec(24, 4, 1);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL err_base got err=%b busy=%b want 1/0", err, busy);
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (cc.size() != 0 || err_cnt != 1) begin
         errors++;
         $display("FAIL err_base_ram ce1=%0d errs=%0d want 0/1",
                  cc.size(), err_cnt);
      end
      clear();
      start_vec(3, 25, 1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (err_cnt != 1 || cc.size() != 0) begin
         errors++;
         $display("FAIL err_len errs=%0d ce1=%0d want 1/0", err_cnt, cc.size());
      end
      clear();
      start_vec(3, 0, 1);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL len0 got done=%b busy=%b err=%b want 1/0/0",
                  done, busy, err);
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (bd.size() != 0 || cc.size() != 0 || done_cnt != 1) begin
         errors++;
         $display("FAIL len0_quiet beats=%0d ce1=%0d done=%0d want 0/0/1",
                  bd.size(), cc.size(), done_cnt);
      end
   endtask

   task automatic test_busy_ignore();
      bit to;
      int bad = 0;
      clear(); m_ready = 1'b1;
      start_vec(2, 4, 1);
      start = 1'b1; base = 5'd10; len = 6'd3;
      @(posedge clk); #1;
      base = 5'd30;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(60, 0, to);
      repeat (5) @(posedge clk);
      #1;
      if (to || bd.size() != 4) bad++;
      else for (int k = 0; k < 4; k++)
         if (bd[k] !== ram[2 + k]) bad++;
      checks++;
      if (bad != 0 || err_cnt != 0 || done_cnt != 1 || cc.size() != 4) begin
         errors++;
         $display("FAIL busy_ignore bad=%0d err=%0d done=%0d ce1=%0d want 0/0/1/4",
                  bad, err_cnt, done_cnt, cc.size());
      end
   endtask

   task automatic test_back_to_back();
      bit to1, to2;
      int bad = 0;
      int exp_a[5] = '{7, 8, 9, 15, 16};
      clear(); m_ready = 1'b1;
      start_vec(7, 3, 1);
      wait_done(60, 0, to1);
      start_vec(15, 2, 1);
      wait_done(60, 0, to2);
      if (to1 || to2 || bd.size() != 5) bad++;
      else for (int k = 0; k < 5; k++)
         if (bd[k] !== ram[exp_a[k]] || bl[k] !== (k == 2 || k == 4)) bad++;
      checks++;
      if (bad != 0 || done_cnt != 2) begin
         errors++;
         $display("FAIL back_to_back bad=%0d done=%0d want 0/2", bad, done_cnt);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int bad = 0;
      int lasts = 0;
      clear(); m_ready = 1'b1;
      start_vec($urandom_range(0, AR - 1), 12, 1);
      for (int i = 0; i < 50; i++) begin
         if (bd.size() >= 3) break;
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, err, ce1, m_valid, m_last} !== 6'b0
          || m_data !== 32'h0 || address1 !== 5'h0) begin
         errors++;
         $display("FAIL mid_reset ctl=%b data=%h addr=%h want 0",
                  {busy, done, err, ce1, m_valid, m_last}, m_data, address1);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      foreach (bl[k]) if (bl[k]) lasts++;
      checks++;
      if (done_cnt != 0 || lasts != 0 || busy !== 1'b0 || bd.size() < 3
          || bd.size() > 5) begin
         errors++;
         $display("FAIL mid_trunc done=%0d lasts=%0d busy=%b beats=%0d want 0/0/0/3..5",
                  done_cnt, lasts, busy, bd.size());
      end
      clear();
      start_vec(5, 2, 1);
      wait_done(40, 0, to);
      if (to || bd.size() != 2) bad++;
      else if (bd[0] !== ram[5] || bd[1] !== ram[6] || bl[0] || !bl[1]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_restart bad=%0d beats=%0d want 0/2", bad, bd.size());
      end
   endtask

`ifdef MPC_QP_ADMM_VX_STRIDE_EN
   task automatic test_stride();
      bit to;
      int bad = 0;
      clear(); m_ready = 1'b1;
      start_vec(1, 6, 5);
      wait_done(60, 0, to);
      if (to || aq.size() != 6 || bd.size() != 6) bad++;
      else for (int k = 0; k < 6; k++)
         if (aq[k] != (1 + 5 * k) % AR || bd[k] !== ram[(1 + 5 * k) % AR]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stride5 bad=%0d addrs=%0d want 0/6", bad, aq.size());
      end
      clear();
      start_vec(4, 3, 0);
      wait_done(40, 0, to);
      bad = 0;
      if (to || bd.size() != 3) bad++;
      else foreach (bd[k]) if (bd[k] !== ram[4]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stride0 bad=%0d beats=%0d want 0/3", bad, bd.size());
      end
      clear();
      start_vec(4, 3, 24);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (err_cnt != 1 || cc.size() != 0) begin
         errors++;
         $display("FAIL stride_bad errs=%0d ce1=%0d want 1/0", err_cnt, cc.size());
      end
   endtask
`endif

   initial begin
      foreach (ram[i]) ram[i] = $urandom;
      q1 = '0;
      clear();
      test_reset();
      test_full();
      test_wrap();
      test_backpressure();
      test_random();
      test_errors();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
`ifdef MPC_QP_ADMM_VX_STRIDE_EN
      test_stride();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mpc_qp_admm_vx_stream_reader.md
MPC_QP_ADMM_VX_STREAM_READER -- requirements
Module: mpc_qp_admm_vx_stream_reader

Interface
REQ-001 Parameter DataWidth, default 32, RAM word width.
REQ-002 Parameter AddressWidth, default 5, RAM address width.
REQ-003 Parameter AddressRange, default 24, number of valid RAM words.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to stream a vector; sampled only in IDLE.
REQ-007 base  in  AddressWidth  first element address; sampled with start.
REQ-008 len  in  AddressWidth+1  element count 0..AddressRange; sampled with start.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  one-cycle pulse on a rejected start.
REQ-012 address1  out  AddressWidth  RAM read-port address.
REQ-013 ce1  out  1  RAM read-port enable.
REQ-014 q1  in  DataWidth  RAM read data, valid one cycle after ce1.
REQ-015 m_data  out  DataWidth  stream payload.
REQ-016 m_valid  out  1  stream valid.
REQ-017 m_ready  in  1  stream ready (backpressure).
REQ-018 m_last  out  1  marks the final element; qualified by m_valid.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN; reset and completion both return to IDLE.
REQ-020 IDLE->RUN: start=1 with base<AddressRange and 1<=len<=AddressRange.
REQ-021 start with base>=AddressRange or len>AddressRange: stay in IDLE, pulse err next cycle, no RAM access.
REQ-022 start with len=0: stay in IDLE, pulse done next cycle, no RAM access, no beats, busy stays low.
REQ-023 start while busy: ignored; no err.
REQ-024 Element k address = (base + k*stride) mod AddressRange; wrap by conditional subtraction, no divider; address1 never >= AddressRange.
REQ-025 ce1 asserts only when (reads in flight + buffered words) < 2; address1 is don't-care when ce1=0.
REQ-026 RUN->DRAIN when the len-th read is issued; DRAIN->IDLE on the m_last handshake.
REQ-027 Elements are delivered in issue order through a 2-entry skid buffer fed by q1 one cycle after each ce1.
REQ-028 Handshake: beat transfers when m_valid&m_ready; m_data/m_last hold stable while m_valid=1 and m_ready=0.
REQ-029 Latency: first ce1 in the cycle after the start edge; first m_valid two cycles after the start edge.
REQ-030 With m_ready held high, throughput is one beat per cycle with no bubbles.
REQ-031 m_last=1 only on beat len-1.
REQ-032 done pulses, and busy drops, in the cycle after the m_last handshake.
REQ-033 A start coinciding with the done cycle is accepted; it is sampled in IDLE.

Reset
REQ-034 reset returns FSM to IDLE and flushes the skid buffer; in-flight reads are discarded.
REQ-035 Outputs during and after reset: busy=0, done=0, err=0, ce1=0, m_valid=0, m_last=0, m_data=0, address1=0.
REQ-036 reset mid-transfer truncates the stream with no m_last and no done; a partially delivered vector is not resumed.

Configuration
REQ-037 Macro MPC_QP_ADMM_VX_STRIDE_EN defined: adds input port stride (AddressWidth bits), sampled with start.
REQ-038 stride>=AddressRange is rejected with err; stride=0 legal and repeats element base len times.
REQ-039 Macro undefined: stride port absent and stride fixed at 1.

Structure
REQ-040 Package mpc_qp_admm_vx_pkg holds the FSM state typedef, the default DataWidth/AddressWidth/AddressRange constants and the skid depth constant (2).
REQ-041 Sub-module mpc_qp_admm_vx_skid implements the 2-entry buffer: data+last in, valid/ready out; no other sub-modules.

Verification
REQ-042 base=0, len=24, m_ready=1: data = RAM[0..23] on consecutive cycles, m_last on beat 23, done once, 24 ce1 pulses.
REQ-043 base=20, len=8: addresses 20,21,22,23,0,1,2,3; m_last on beat 7.
REQ-044 len=10, m_ready toggling 1-0-0-1 randomly: all 10 words delivered once, in order; m_data stable while stalled; in-flight+buffered never >2.
REQ-045 start with base=24 -> err pulse, no ce1; start with len=0 -> done pulse next cycle, no beats; start while busy -> ignored.
REQ-046 reset asserted after beat 3 of len=12: all outputs 0 next cycle, no done; a new start base=5, len=2 then streams RAM[5], RAM[6] normally.
REQ-047 With MPC_QP_ADMM_VX_STRIDE_EN: base=1, stride=5, len=6 -> addresses 1,6,11,16,21,2.
